// File: rtl/pio_shift_out_pkg.sv
// Shared types and constants for the PIO-to-74HC595 serialiser.
package pio_shift_out_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  // Bit presented on sdata for the current shift position.
  function automatic logic current_bit(input logic [FRAME_BITS-1:0] v, input bit msb_first);
    return msb_first ? v[FRAME_BITS-1] : v[0];
  endfunction

  // Move the next bit into the position read by current_bit.
  function automatic logic [FRAME_BITS-1:0] shift_advance(input logic [FRAME_BITS-1:0] v,
                                                          input bit msb_first);
    return msb_first ? {v[FRAME_BITS-2:0], 1'b0} : {1'b0, v[FRAME_BITS-1:1]};
  endfunction

endpackage

// File: rtl/pio_shift_tick.sv
// Phase counter: counts 0..CLK_DIV-1, flags the last cycle of each phase.
module pio_shift_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic last
);

  logic [7:0] phase_reg;

  assign last = (phase_reg == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || restart || last) begin
      phase_reg <= 8'd0;
    end else begin
      phase_reg <= phase_reg + 8'd1;
    end
  end

endmodule

// File: rtl/pio_shift_out.sv
// Serialises an 8-bit PIO pattern into a 74HC595-style register whenever it changes.
module pio_shift_out
  import pio_shift_out_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] data_in,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  latch,
  output logic                  busy
);

  state_t                state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [FRAME_BITS-1:0] sent_reg, sent_next;
  logic [2:0]            bit_cnt_reg, bit_cnt_next;
  logic                  pending_reg, pending_next;
  logic                  sclk_reg, sdata_reg, latch_reg, busy_reg;
  logic                  phase_last;
  logic                  restart;

  // Any state change restarts the phase so every state gets a full CLK_DIV.
  assign restart = (state_next != state_reg);

  pio_shift_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .last   (phase_last)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    sent_next    = sent_reg;
    bit_cnt_next = bit_cnt_reg;
    pending_next = pending_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg || (data_in != sent_reg)) state_next = LOAD;
      end
      LOAD: begin
        shift_next   = data_in;
        sent_next    = data_in;
        pending_next = 1'b0;
        bit_cnt_next = 3'd0;
        state_next   = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_last) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_last) begin
          if (bit_cnt_reg == 3'(FRAME_BITS - 1)) begin
            state_next = LATCH;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = shift_advance(shift_reg, MSB_FIRST);
            state_next   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (phase_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      sent_reg    <= '0;
      bit_cnt_reg <= 3'd0;
      pending_reg <= 1'b1;
      sclk_reg    <= 1'b0;
      sdata_reg   <= 1'b0;
      latch_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      sent_reg    <= sent_next;
      bit_cnt_reg <= bit_cnt_next;
      pending_reg <= pending_next;
      sclk_reg    <= (state_next == SHIFT_HI);
      sdata_reg   <= ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ?
                     current_bit(shift_next, MSB_FIRST) : 1'b0;
      latch_reg   <= (state_next == LATCH);
      busy_reg    <= (state_next != IDLE);
    end
  end

  assign sclk  = sclk_reg;
  assign sdata = sdata_reg;
  assign latch = latch_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_pio_shift_out.sv
// Directed bench for pio_shift_out: three parameterisations share clk and reset.
module tb_pio_shift_out;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_a, data_b, data_c;
  logic       sclk_a, sdata_a, latch_a, busy_a;
  logic       sclk_b, sdata_b, latch_b, busy_b;
  logic       sclk_c, sdata_c, latch_c, busy_c;
  logic       m_sclk, m_sdata, m_latch, m_busy;
  int         sel;
  int         checks = 0;
  int         errors = 0;

  int         cap_started, cap_gap, cap_len, cap_nbits, cap_latch, cap_pulses;
  int         cap_period, cap_glitch;
  logic [7:0] cap_bits;

  always #5 clk = ~clk;

  pio_shift_out #(.CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_a),
    .sclk(sclk_a), .sdata(sdata_a), .latch(latch_a), .busy(busy_a));
  pio_shift_out #(.CLK_DIV(2), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_b),
    .sclk(sclk_b), .sdata(sdata_b), .latch(latch_b), .busy(busy_b));
  pio_shift_out #(.CLK_DIV(1), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .data_in(data_c),
    .sclk(sclk_c), .sdata(sdata_c), .latch(latch_c), .busy(busy_c));

  always_comb begin
    m_sclk = sclk_a; m_sdata = sdata_a; m_latch = latch_a; m_busy = busy_a;
    case (sel)
      1: begin m_sclk = sclk_b; m_sdata = sdata_b; m_latch = latch_b; m_busy = busy_b; end
      2: begin m_sclk = sclk_c; m_sdata = sdata_c; m_latch = latch_c; m_busy = busy_c; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] v);
    case (sel)
      1:       data_b = v;
      2:       data_c = v;
      default: data_a = v;
    endcase
  endtask

  // Waits for a frame on the selected DUT and records its observable shape.
  task automatic capture(input int max_wait, input int at1, input logic [7:0] v1,
                         input int at2, input logic [7:0] v2);
    int   k, first_rise, second_rise;
    logic prev_sclk, prev_latch, held;
    cap_started = 0; cap_gap = 0; cap_len = 0; cap_nbits = 0; cap_latch = 0;
    cap_pulses = 0; cap_period = 0; cap_glitch = 0; cap_bits = 8'h00;
    while (!m_busy && cap_gap < max_wait) begin
      cap_gap++;
      step();
    end
    if (!m_busy) begin
      $display("frame sel=%0d none within %0d cycles", sel, max_wait);
      return;
    end
    cap_started = 1;
    k = 0; first_rise = -1; second_rise = -1;
    prev_sclk = 1'b0; prev_latch = 1'b0; held = 1'b0;
    while (m_busy && k < 200) begin
      if (m_sclk && !prev_sclk) begin
        cap_bits = {cap_bits[6:0], m_sdata};
        cap_nbits++;
        held = m_sdata;
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) second_rise = k;
      end else if (m_sclk && (m_sdata !== held)) begin
        cap_glitch++;
      end
      if (m_latch) begin
        cap_latch++;
        if (!prev_latch) cap_pulses++;
      end
      prev_sclk  = m_sclk;
      prev_latch = m_latch;
      if (k == at1) set_data(v1);
      if (k == at2) set_data(v2);
      k++;
      step();
    end
    cap_len    = k;
    cap_period = second_rise - first_rise;
    $display("frame sel=%0d gap=%0d len=%0d bits=%02h nbits=%0d latch=%0d period=%0d",
             sel, cap_gap, cap_len, cap_bits, cap_nbits, cap_latch, cap_period);
  endtask

  initial begin
    int   k;
    logic lat_seen;
    sel = 0; reset = 1'b1;
    data_a = 8'h00; data_b = 8'h00; data_c = 8'h00;
    repeat (3) step();
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_sclk", 32'(sclk_a), 32'd0);
    check("reset_sdata", 32'(sdata_a), 32'd0);
    check("reset_latch", 32'(latch_a), 32'd0);
    reset = 1'b0;

    // Power-on frame of all zeros.
    capture(10, -1, 8'h00, -1, 8'h00);
    check("por_len", 32'(cap_len), 32'd35);
    check("por_nbits", 32'(cap_nbits), 32'd8);
    check("por_bits", 32'(cap_bits), 32'h00);
    check("por_latch", 32'(cap_latch), 32'd2);
    check("por_period", 32'(cap_period), 32'd4);

    set_data(8'hA5);
    capture(10, -1, 8'h00, -1, 8'h00);
    check("a5_gap", 32'(cap_gap), 32'd1);
    check("a5_bits", 32'(cap_bits), 32'hA5);
    check("a5_pulses", 32'(cap_pulses), 32'd1);
    check("a5_latch", 32'(cap_latch), 32'd2);
    check("a5_glitch", 32'(cap_glitch), 32'd0);
    check("a5_len", 32'(cap_len), 32'd35);

    // Coalescing: 22 and 33 arrive mid-frame, only 33 follows.
    set_data(8'h11);
    capture(10, 3, 8'h22, 10, 8'h33);
    check("co_first_bits", 32'(cap_bits), 32'h11);
    capture(10, -1, 8'h00, -1, 8'h00);
    check("co_second_gap", 32'(cap_gap), 32'd1);
    check("co_second_bits", 32'(cap_bits), 32'h33);
    capture(60, -1, 8'h00, -1, 8'h00);
    check("co_no_third", 32'(cap_started), 32'd0);

    // Abort during the fourth SHIFT_HI (frame cycle 15).
    set_data(8'h5A);
    k = 0;
    while (!busy_a && k < 10) begin k++; step(); end
    check("ab_started", 32'(busy_a), 32'd1);
    lat_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      lat_seen = lat_seen | latch_a;
      step();
    end
    check("ab_in_hi", 32'(sclk_a), 32'd1);
    reset = 1'b1;
    step();
    check("ab_busy", 32'(busy_a), 32'd0);
    check("ab_sclk", 32'(sclk_a), 32'd0);
    check("ab_latch", 32'(latch_a | lat_seen), 32'd0);
    reset = 1'b0;
    capture(10, -1, 8'h00, -1, 8'h00);
    check("ab_refresh", 32'(cap_started), 32'd1);
    check("ab_bits", 32'(cap_bits), 32'h5A);
    check("ab_pulses", 32'(cap_pulses), 32'd1);

    // LSB-first unit.
    repeat (40) step();
    sel = 1;
    set_data(8'h01);
    capture(10, -1, 8'h00, -1, 8'h00);
    check("lsb_bits", 32'(cap_bits), 32'h80);
    check("lsb_nbits", 32'(cap_nbits), 32'd8);

    // CLK_DIV=1 unit.
    sel = 2;
    set_data(8'hFF);
    capture(10, -1, 8'h00, -1, 8'h00);
    check("div1_len", 32'(cap_len), 32'd18);
    check("div1_period", 32'(cap_period), 32'd2);
    check("div1_bits", 32'(cap_bits), 32'hFF);
    check("div1_latch", 32'(cap_latch), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
